// File: rtl/aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched
//
// Sequential AES-128 key scheduler for the decryption datapath. A start in IDLE
// loads the cipher key, then ten EXPAND cycles walk the key forward to round
// key 10. In OUT the round keys are returned 10, 9, ..., 0 over a valid/ready
// stream. Each earlier key is rebuilt by running the expansion recurrence
// backwards, so only one 128-bit key register is ever held.
//
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request a new schedule (honoured only in IDLE)
//   key       128-bit cipher key, word 0 in [127:96]
//   busy      high in every state except IDLE
//   rk_valid  rk_data / rk_round hold a valid round key
//   rk_ready  consumer accepts the key on an edge with rk_valid && rk_ready
//   rk_data   round key, word 0 in [127:96]
//   rk_round  round index of rk_data, 10 down to 0
//   done      one-cycle pulse after round 0 has been accepted
// -----------------------------------------------------------------------------

// AES S-box computed arithmetically: multiplicative inverse in GF(2^8) as
// x^254, followed by the affine transform.
module aes_sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Square-and-multiply chain: inv collects x^2 * x^4 * ... * x^128 = x^254,
    // which is also 0 for x = 0 as the S-box requires.
    always_comb begin
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = byte_val;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sub_val = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;
    end

endmodule

module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] kr;
    logic [3:0]   rc;
    logic [7:0]   rcon;

    logic [31:0] a0, a1, a2, a3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] sub_in, rot, sub_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Backward steps need Rcon of the round currently held, so a small table
    // indexed by rc avoids an inverse-xtime circuit.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign a0 = kr[127:96];
    assign a1 = kr[95:64];
    assign a2 = kr[63:32];
    assign a3 = kr[31:0];

    // Previous round's words 1..3 fall straight out of the XOR chain.
    assign p3 = a3 ^ a2;
    assign p2 = a2 ^ a1;
    assign p1 = a1 ^ a0;

    // The four S-boxes are shared: forward rounds substitute a3, backward
    // rounds substitute the recovered previous a3 (p3).
    assign sub_in = (state == OUT) ? p3 : a3;
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .byte_val (rot[8*g +: 8]),
            .sub_val  (sub_out[8*g +: 8])
        );
    end

    assign n0 = a0 ^ sub_out ^ {rcon, 24'h0};
    assign n1 = a1 ^ n0;
    assign n2 = a2 ^ n1;
    assign n3 = a3 ^ n2;

    assign p0 = a0 ^ sub_out ^ {rcon_of(rc), 24'h0};

    assign busy     = (state != IDLE);
    assign rk_data  = kr;
    assign rk_round = rc;

    // Main sequencer: load in IDLE, ten forward rounds in EXPAND, then one
    // backward step per accepted key in OUT until round 0 leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            kr       <= '0;
            rc       <= '0;
            rcon     <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rk_valid <= 1'b0;
                    if (start) begin
                        kr    <= key;
                        rc    <= 4'd0;
                        rcon  <= 8'h01;
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    kr   <= {n0, n1, n2, n3};
                    rc   <= rc + 4'd1;
                    rcon <= xtime(rcon);
                    if (rc == 4'd9) begin
                        state    <= OUT;
                        rk_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (rk_ready) begin
                        if (rc != 4'd0) begin
                            kr <= {p0, p1, p2, p3};
                            rc <= rc - 4'd1;
                        end else begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rk_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_sched
//
// Self-checking bench for aes_inv_key_sched. A reference model builds the
// FIPS-197 word schedule w[0..43] from a lookup-table S-box and the expected
// key stream is that schedule read back from round 10 to round 0. Fixed
// known-answer vectors sit in a table; randomized keys and random rk_ready
// stalls exercise the stream, plus hand-written start/reset corner cases.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [127:0] model_rk [0:10];
    logic [127:0] got_rk   [0:10];

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_inv_key_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    task automatic compute_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcv;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rcv = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t   = sub_word({t[23:0], t[31:24]}) ^ {rcv, 24'h0};
                rcv = rcv[7] ? ({rcv[6:0], 1'b0} ^ 8'h1b) : {rcv[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
        key   = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        checkOutput({tag, "_busy"},     128'(busy),     128'd0);
        checkOutput({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        checkOutput({tag, "_rk_data"},  rk_data,        128'd0);
        checkOutput({tag, "_rk_round"}, 128'(rk_round), 128'd0);
        checkOutput({tag, "_done"},     128'(done),     128'd0);
    endtask

    task automatic wait_valid(input int expected);
        int n;
        n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (rk_valid === 1'b1) break;
        end
        checkOutput("valid_latency", 128'(n), 128'(expected));
    endtask

    // Drains the stream from round 10, stopping early when stop_round is hit.
    task automatic drain(input bit rnd, input int stop_round);
        int r;
        int cyc;
        bit rdy;
        r   = 10;
        cyc = 0;
        while (r >= 0 && r != stop_round && cyc < 400) begin
            checkOutput("stream_valid", 128'(rk_valid), 128'd1);
            checkOutput("stream_round", 128'(rk_round), 128'(r));
            checkOutput("stream_data",  rk_data,        model_rk[r]);
            checkOutput("stream_done",  128'(done),     128'd0);
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            rk_ready = rdy;
            if (rdy) got_rk[r] = rk_data;
            tick();
            cyc++;
            if (rdy) r--;
        end
        rk_ready = 1'b0;
        if (stop_round < 0) begin
            checkOutput("drain_complete", 128'(r < 0), 128'd1);
            checkOutput("done_pulse",     128'(done),     128'd1);
            checkOutput("end_valid",      128'(rk_valid), 128'd0);
            checkOutput("end_busy",       128'(busy),     128'd0);
        end
    endtask

    task automatic run_full(input logic [127:0] k, input bit rnd);
        compute_model(k);
        applyStimulus(k);
        checkOutput("busy_after_start", 128'(busy), 128'd1);
        wait_valid(10);
        drain(rnd, -1);
        tick();
        checkOutput("done_single", 128'(done), 128'd0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_zero_outputs(tag);
        tick();
        check_zero_outputs({tag, "_held"});
        rst_n = 1'b1;
        tick();
        checkOutput({tag, "_no_done"}, 128'(done), 128'd0);
        checkOutput({tag, "_idle"},    128'(busy), 128'd0);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] rk10;
        bit           has9;
        logic [127:0] rk9;
        logic [127:0] rk1;
    } vec_t;

    vec_t vecs [2];

    initial begin
        logic [127:0] k1, k2, k3;

        vecs[0] = '{key:  128'h2b7e151628aed2a6abf7158809cf4f3c,
                    rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    has9: 1'b1,
                    rk9:  128'hac7766f319fadc2128d12941575c006e,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[1] = '{key:  128'h0,
                    rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                    has9: 1'b0,
                    rk9:  128'h0,
                    rk1:  128'h62636363626363636263636362636363};

        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b0;
        #2;
        check_zero_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Idle with no start: nothing should move.
        for (int i = 0; i < 50; i++) begin
            checkOutput("idle_quiet", 128'({busy, rk_valid, done}), 128'd0);
            tick();
        end

        // Known-answer table.
        for (int v = 0; v < 2; v++) begin
            run_full(vecs[v].key, 1'b0);
            checkOutput("kat_round10", got_rk[10], vecs[v].rk10);
            if (vecs[v].has9) checkOutput("kat_round9", got_rk[9], vecs[v].rk9);
            checkOutput("kat_round1", got_rk[1], vecs[v].rk1);
            checkOutput("kat_round0", got_rk[0], vecs[v].key);
        end

        // start during EXPAND and during OUT is ignored.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        compute_model(k1);
        applyStimulus(k1);
        tick();
        tick();
        tick();
        applyStimulus(k2);
        wait_valid(6);
        applyStimulus(k2);
        checkOutput("ignore_out_round", 128'(rk_round), 128'd10);
        checkOutput("ignore_out_data",  rk_data,        model_rk[10]);
        drain(1'b1, -1);

        // start on the same edge where done is high.
        compute_model(k3);
        applyStimulus(k3);
        checkOutput("restart_busy", 128'(busy), 128'd1);
        wait_valid(10);
        drain(1'b0, -1);
        tick();

        // Reset during EXPAND round 5.
        compute_model(k1);
        applyStimulus(k1);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("pre_reset_round", 128'(rk_round), 128'd5);
        pulse_reset("rst_expand");
        run_full(k2, 1'b1);

        // Reset during OUT at round 3.
        compute_model(k3);
        applyStimulus(k3);
        wait_valid(10);
        drain(1'b1, 3);
        checkOutput("pre_reset_out", 128'(rk_round), 128'd3);
        pulse_reset("rst_out");
        run_full(k3, 1'b0);

        // Randomized keys with random back-pressure.
        for (int i = 0; i < 200; i++) begin
            run_full({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
